// File: rtl/tx_bit_timer_pkg.sv
// Shared types and configuration limits for the transmit bit timer.
package tx_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_tmr_state_t;

    localparam int unsigned MIN_BIT_PERIOD = 2;
    localparam int unsigned MIN_DATA_LEN   = 1;

endpackage

// File: rtl/tx_bit_timer_flex_counter.sv
// Generic up-counter that runs 0..rollover_val-1 and wraps back to 0.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic at_last;

    assign at_last = (count_out == (rollover_val - NUM_CNT_BITS'(1)));

    // Clear wins over counting so a restart never sees a stale count.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= at_last ? '0 : count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/tx_bit_timer.sv
// Programmable bit/packet timer: shift, mid-bit and packet-end strobes for the TX shifter.
module tx_bit_timer
    import tx_timer_pkg::*;
#(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned LEN_W    = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [LEN_W-1:0]    data_len,
    input  logic                continuous,
    output logic                busy,
    output logic                shift_enable,
    output logic                mid_strobe,
    output logic                byte_sent,
    output logic                cfg_err
);

    tx_tmr_state_t       state, state_n;
    logic [PERIOD_W-1:0] period_q, period_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [PERIOD_W-1:0] clk_cnt, clk_cnt_n;
    logic [LEN_W-1:0]    bit_cnt;
    logic                cfg_err_q, cfg_err_n;
    logic                bit_clear;

    logic running;
    logic at_period;
    logic bit_last;
    logic packet_end;
    logic cfg_ok;

    assign running    = (state == RUN);
    assign at_period  = running && (clk_cnt == period_q);
    assign bit_last   = (bit_cnt == (len_q - LEN_W'(1)));
    assign packet_end = at_period && bit_last;
    assign cfg_ok     = (bit_period >= PERIOD_W'(MIN_BIT_PERIOD)) &&
                        (data_len >= LEN_W'(MIN_DATA_LEN));

    // Abort is the only input allowed to reach the outputs combinationally.
    assign busy         = running;
    assign shift_enable = at_period && !abort;
    assign mid_strobe   = running && (clk_cnt == (period_q >> 1)) && !abort;
    assign byte_sent    = shift_enable && bit_last;
    assign cfg_err      = cfg_err_q;

    flex_counter #(
        .NUM_CNT_BITS (LEN_W)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (bit_clear),
        .count_enable (shift_enable),
        .rollover_val (len_q),
        .count_out    (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            period_q  <= '0;
            len_q     <= '0;
            clk_cnt   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            period_q  <= period_n;
            len_q     <= len_n;
            clk_cnt   <= clk_cnt_n;
            cfg_err_q <= cfg_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        period_n  = period_q;
        len_n     = len_q;
        clk_cnt_n = clk_cnt;
        cfg_err_n = 1'b0;
        bit_clear = 1'b0;

        if (abort) begin
            state_n   = IDLE;
            clk_cnt_n = '0;
            bit_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            period_n  = bit_period;
                            len_n     = data_len;
                            clk_cnt_n = PERIOD_W'(1);
                            bit_clear = 1'b1;
                            state_n   = RUN;
                        end else begin
                            cfg_err_n = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (packet_end) begin
                        // A continuous chain relatches config so the next packet has no dead cycle.
                        bit_clear = 1'b1;
                        if (continuous && cfg_ok) begin
                            period_n  = bit_period;
                            len_n     = data_len;
                            clk_cnt_n = PERIOD_W'(1);
                        end else begin
                            cfg_err_n = continuous;
                            clk_cnt_n = '0;
                            state_n   = IDLE;
                        end
                    end else if (at_period) begin
                        clk_cnt_n = PERIOD_W'(1);
                    end else begin
                        clk_cnt_n = clk_cnt + PERIOD_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_bit_timer.sv
// Randomized scoreboard bench for tx_bit_timer against a cycle-schedule reference model.
module tb_tx_bit_timer;

    localparam int PW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          continuous = 1'b0;
    logic [PW-1:0] bit_period = '0;
    logic [LW-1:0] data_len = '0;
    logic          busy, shift_enable, mid_strobe, byte_sent, cfg_err;

    // Expected strobe vector per cycle: {cfg_err, byte_sent, shift_enable, mid_strobe}
    typedef struct {
        int       cyc;
        logic [3:0] ev;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  busy_start = 1;
    int  busy_end = 0;
    bit  mon_on = 1'b0;

    tx_bit_timer #(
        .PERIOD_W (PW),
        .LEN_W    (LW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .bit_period   (bit_period),
        .data_len     (data_len),
        .continuous   (continuous),
        .busy         (busy),
        .shift_enable (shift_enable),
        .mid_strobe   (mid_strobe),
        .byte_sent    (byte_sent),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushEv(input int c, input logic [3:0] e);
        ev_t x;
        x.cyc = c;
        x.ev  = e;
        exp_q.push_back(x);
    endfunction

    // Packet accepted at the edge closing cycle 'base': bit n has its mid at n*P+P/2
    // and its shift at (n+1)*P; the final shift also carries byte_sent.
    function automatic void modelPacket(input int base, input int p, input int l);
        for (int n = 0; n < l; n++) begin
            pushEv(base + n * p + p / 2, 4'b0001);
            pushEv(base + (n + 1) * p, (n == l - 1) ? 4'b0110 : 4'b0010);
        end
        busy_end = base + l * p;
    endfunction

    function automatic void dropFrom(input int c);
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= c)
            void'(exp_q.pop_back());
        if (busy_end >= c)
            busy_end = c - 1;
    endfunction

    always @(negedge clk) begin
        logic [3:0] act;
        logic       exp_busy;
        ev_t        e;
        if (mon_on) begin
            act      = {cfg_err, byte_sent, shift_enable, mid_strobe};
            exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("[TB] FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, exp_busy);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missed_event cyc=%0d actual=none required=%b", e.cyc, e.ev);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e.ev) begin
                    bad++;
                    $display("[TB] FAIL strobes cyc=%0d actual=%b required=%b", cyc, act, e.ev);
                end
            end else if (act !== 4'b0000) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe cyc=%0d actual=%b required=0000", cyc, act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expv);
        logic [4:0] act;
        @(negedge clk);
        act = {busy, cfg_err, byte_sent, shift_enable, mid_strobe};
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, expv);
        end
    endtask

    task automatic applyStimulus(input int p, input int l);
        bit_period = PW'(p);
        data_len   = LW'(l);
        start      = 1'b1;
        if (p >= 2 && l >= 1) begin
            busy_start = cyc + 1;
            modelPacket(cyc, p, l);
        end else begin
            pushEv(cyc + 1, 4'b1000);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic chainPacket(input int p, input int l);
        int e;
        e          = busy_end;
        continuous = 1'b1;
        bit_period = PW'(p);
        data_len   = LW'(l);
        if (p >= 2 && l >= 1)
            modelPacket(e, p, l);
        else
            pushEv(e + 1, 4'b1000);
        while (cyc <= e) tick();
        continuous = 1'b0;
    endtask

    task automatic abortAt(input int a);
        while (cyc < a) tick();
        abort = 1'b1;
        dropFrom(a);
        if (busy_end == a - 1 && busy_start <= a)
            busy_end = a;
        tick();
        abort = 1'b0;
    endtask

    task automatic waitIdle();
        while (cyc <= busy_end) tick();
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int base;
        int p, l, r;
        tick();
        tick();
        n_rst = 1'b1;
        mon_on = 1'b1;
        checkOutput("reset_state", 5'b00000);
        tick();

        applyStimulus(8, 8);
        waitIdle();

        applyStimulus(3, 2);
        chainPacket(3, 2);
        chainPacket(5, 2);
        waitIdle();

        base = cyc;
        applyStimulus(4, 4);
        abortAt(base + 10);
        applyStimulus(4, 4);
        waitIdle();

        applyStimulus(1, 4);
        waitIdle();
        applyStimulus(4, 0);
        waitIdle();

        start = 1'b1; abort = 1'b1; bit_period = PW'(1);
        tick();
        bit_period = PW'(4); data_len = LW'(2);
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_idle", 5'b00000);
        tick();

        applyStimulus(5, 3);
        tick(); tick();
        start = 1'b1; bit_period = PW'(2); data_len = LW'(1);
        tick();
        start = 1'b0;
        waitIdle();

        base = cyc;
        applyStimulus(6, 4);
        while (cyc < base + 9) tick();
        n_rst = 1'b0;
        dropFrom(base + 10);
        tick();
        checkOutput("reset_mid_run", 5'b00000);
        tick();
        n_rst = 1'b1;
        tick();

        applyStimulus(2, 3);
        chainPacket(1, 3);
        waitIdle();

        for (int it = 0; it < 12; it++) begin
            p = int'($urandom_range(2, 9));
            l = int'($urandom_range(1, 5));
            r = int'($urandom_range(0, 9));
            base = cyc;
            applyStimulus(p, l);
            if (r < 3) begin
                if (r == 0)
                    chainPacket(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
                else
                    chainPacket(int'($urandom_range(2, 7)), int'($urandom_range(1, 4)));
            end else if (r < 6) begin
                abortAt(base + int'($urandom_range(1, p * l)));
            end
            waitIdle();
        end

        applyStimulus(255, 15);
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_bit_timer.md
# tx_bit_timer

Programmable bit/packet timer for the transmit path. Sits between the TX controller FSM and the TX shift register. Generates one `shift_enable` pulse per bit period, a mid-bit `mid_strobe`, and `byte_sent` at packet end. Unlike the fixed 8-cycle/8-bit timer, this block supports:
- per-packet runtime bit period and packet length,
- a start/busy handshake,
- abort,
- back-to-back continuous packets.

## Interface
Parameters:
- `PERIOD_W`, default 8: width of `bit_period`.
- `LEN_W`, default 4: width of `data_len`.

Ports:
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a packet; sampled only in IDLE.
- `abort` in 1: terminate immediately; highest priority.
- `bit_period` in `PERIOD_W`: clock cycles per bit; legal range 2..2^PERIOD_W-1; latched on accepted start.
- `data_len` in `LEN_W`: bits per packet; legal range 1..2^LEN_W-1; latched on accepted start.
- `continuous` in 1: sampled at each packet end; 1 starts the next packet with no gap.
- `busy` out 1: high in RUN.
- `shift_enable` out 1: one-cycle pulse at the end of each bit period.
- `mid_strobe` out 1: one-cycle pulse at mid-bit.
- `byte_sent` out 1: one-cycle pulse, coincident with the last `shift_enable` of a packet.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, RUN.
- Registers:
  - `period_q`, `len_q`: latched config.
  - `clk_cnt` (`PERIOD_W`): cycle within the bit, range 1..`period_q`.
  - `bit_cnt` (`LEN_W`): bits completed.
- Priority at each edge is `n_rst`=0, then `abort`, then all other events.
- `n_rst`=0: state IDLE; all counters and config registers 0; all outputs 0.
- IDLE:
  - `start`=1 with legal config: latch `bit_period`/`data_len`, set `clk_cnt`=1, `bit_cnt`=0, go to RUN.
  - `start`=1 with `bit_period`<2 or `data_len`=0: pulse `cfg_err` on the next cycle and stay IDLE.
  - `start` together with `abort`: stay IDLE, no `cfg_err`.
- RUN:
  - `clk_cnt` increments each cycle.
  - When `clk_cnt`==`period_q`: `clk_cnt` returns to 1 and `bit_cnt` increments.
  - `start` is ignored. Config inputs are ignored until the next latch.
- Packet end: `clk_cnt`==`period_q` and `bit_cnt`==`len_q`-1.
  - `continuous`=1: relatch `bit_period`/`data_len` if legal, reset counters, stay in RUN.
  - `continuous`=1 with illegal new config: pulse `cfg_err` and go to IDLE.
  - `continuous`=0: go to IDLE.
- `abort` in RUN: go to IDLE on the next edge and clear counters. No `byte_sent`; `shift_enable`/`mid_strobe` are suppressed in the abort cycle.
- Outputs are decoded from registered state with no input-to-output paths, except that `abort` gates the strobes:
  - `busy` = (state==RUN).
  - `shift_enable` = RUN & `clk_cnt`==`period_q`.
  - `mid_strobe` = RUN & `clk_cnt`==`period_q`>>1 (floor). `bit_period`=2 gives mid at `clk_cnt`=1.
  - `byte_sent` = `shift_enable` & `bit_cnt`==`len_q`-1.
- Counter width rule: compare at full register width. `clk_cnt` never exceeds `period_q`, so it never wraps.

## Timing
- Cycle numbering: start is accepted at edge E0; cycle k is the cycle after edge E0+k-1.
- `busy` is high from cycle 1.
- Bit n (n = 0-based):
  - `shift_enable` is high in cycle (n+1)·P.
  - `mid_strobe` is high in cycle n·P + floor(P/2).
- `byte_sent` is high in cycle L·P.
- `busy` falls after cycle L·P unless `continuous`=1.
- Minimum IDLE-to-RUN gap between non-continuous packets: 1 cycle, because `start` is only sampled when `busy`=0.
- `cfg_err`: high in cycle 1 after the rejected `start`.
- Continuous mode: the next packet's cycle 1 immediately follows cycle L·P. There are no dead cycles.

## Structure
- Package `tx_timer_pkg`:
  - `typedef enum logic {IDLE, RUN} tx_tmr_state_t`.
  - `MIN_BIT_PERIOD`=2.
  - `MIN_DATA_LEN`=1.
- Natural sub-module: reuse the existing `flex_counter` for the bit counter, with rollover value `len_q` and count enable from `shift_enable`.
- Keep the cycle counter inline, because the mid-bit compare needs its value.

## Test plan
- Reset: drive `n_rst`=0 mid-RUN → the next cycle has all outputs 0, `busy`=0, state IDLE.
- P=8, L=8, one start → `shift_enable` in cycles 8,16,…,64; `mid_strobe` in cycles 4,12,…,60; `byte_sent` only in cycle 64; `busy` low in cycle 65.
- P=3, L=2, `continuous`=1 for 2 packets, then 0 → `byte_sent` in cycles 6 and 12 with no gap; second packet uses newly latched P=5 if changed before cycle 6; `busy`=0 after.
- `abort` in cycle 10 of P=4, L=4 → no strobes in cycle 10, `busy`=0 from cycle 11, no `byte_sent`; a new start in cycle 11 is accepted.
- Start with P=1, and separately with L=0 → `cfg_err` pulse in cycle 1, `busy` stays 0. Start+abort in the same cycle → nothing.
- `start` pulsed while `busy` → ignored, timing unchanged. Max config P=255, L=15 → `byte_sent` in cycle 3825.
